work_transmit: RTL
==================

Name: work_transmit

Overview:
- Host-side counterpart of the 64-byte work receiver: serializes one 512-bit work packet (256-bit midstate, then 256-bit data2) onto an RS-232 line, 8N1.
- Used in the loopback/test harness and on the host-emulation FPGA to feed the miner.
- Byte order matches the receiver's shift-left assembly: midstate[255:248] goes first and data2[7:0] goes last. A packet sent here therefore reappears bit-identical on the receiver's midstate/data2 outputs.

Parameters:
- CLK_FRQ, 50_000_000, clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. Bit period BIT_CYC = CLK_FRQ/BAUD (integer, truncated); BIT_CYC must be >= 2.
- NBYTES, 64, payload bytes per packet. Fixed at 64 for the miner; the parameter exists for bench shrinking only.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- midstate  in  256  first half of packet; sampled only on accept.
- data2  in  256  second half of packet; sampled only on accept.
- send  in  1  request; accepted on a clk edge where send=1 and busy=0.
- busy  out  1  high from the cycle after accept until the packet completes.
- done  out  1  one-cycle pulse when the final stop bit ends.
- TxD  out  1  serial line; idle high.

Behaviour:
- Reset state (async assert, sync release): TxD=1, busy=0, done=0, FSM=IDLE, all counters 0. Reset asserted mid-packet aborts the packet immediately; TxD returns high in the same instant.
- Accept:
  - On the edge where send && !busy, {midstate,data2} is copied into a 512-bit shift register.
  - FSM goes to START and busy=1 from the next cycle.
  - send is ignored while busy; input changes after accept have no effect.
- FSM states, all driven by baud_cnt counting 0..BIT_CYC-1:
  - IDLE: TxD=1.
  - START: TxD=0 for BIT_CYC cycles, then DATA.
  - DATA: TxD=shreg[504+bit_idx] (LSB of the current top byte first), bit_idx 0..7, BIT_CYC cycles each. After bit 7, go to STOP.
  - STOP: TxD=1 for BIT_CYC cycles. At the end, shreg shifts left 8. If byte_cnt==NBYTES-1, go to IDLE with done=1 and busy=0 on that edge. Otherwise byte_cnt++ and go to START. There is no extra inter-byte gap.
- Latency: the first start-bit edge on TxD appears 1 cycle after the accept edge. Packet duration is exactly NBYTES*10*BIT_CYC cycles of busy.
- Back-to-back: send may be high in the done cycle; because busy=0 there, it is accepted, and the next start bit follows immediately after the stop bit.
- Counters:
  - byte_cnt is 7 bits wide and never wraps past NBYTES-1.
  - baud_cnt is wide enough for BIT_CYC-1 and resets to 0 on every state change.
- TxD is driven from a register (glitch-free).

Optional Feature:
- Macro WORK_TX_CHECKSUM_EN.
- Defined: after the NBYTES payload bytes, one extra byte is sent (same 8N1 framing) holding the XOR of all payload bytes. The XOR is accumulated as bytes load and cleared on accept. busy lasts (NBYTES+1)*10*BIT_CYC cycles, and done pulses after the checksum stop bit.
- Undefined: exactly NBYTES bytes are sent, with no accumulator logic.

Decomposition:
- Package work_tx_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, STOP);
  - the BIT_CYC computation function;
  - the packet width constant 512.
- Sub-module uart_tx_core holds the one-byte 8N1 serializer: start/byte in, busy out, TxD. work_transmit keeps the packet shift register, byte counter, checksum and done/busy logic, and launches uart_tx_core one byte per STOP completion. Both must meet the cycle timing above exactly.

Test Plan (bench CLK_FRQ=1_000_000, BAUD=100_000 -> BIT_CYC=10):
- Reset then idle: TxD=1, busy=0, done=0 for 100 cycles; a send pulse one cycle later produces TxD=0 on the next edge.
- midstate=256'h00..01, data2 with byte 0 = 8'hA5 -> first byte on the line is 8'h00 and last is 8'hA5, sampled mid-bit as bits 1,0,1,0,0,1,0,1. busy stays high for 6400 cycles, and a single done pulse follows.
- Loopback to the existing receiver at the same baud with random midstate/data2 -> the receiver outputs match the inputs exactly after done.
- send held high continuously -> two packets back-to-back with no idle gap between the last stop bit and the next start bit; inputs changed mid-packet do not alter the first packet.
- rst_n asserted at cycle 3000 of a packet -> TxD=1 and busy=0 asynchronously; after release, a new send transmits a full, correct packet.
- WORK_TX_CHECKSUM_EN defined, payload all 8'h5A except data2[7:0]=8'hFF -> the 65th byte is 8'hA5 and busy lasts 6500 cycles.

Source files
------------

// File: rtl/work_tx_pkg.sv
// -----------------------------------------------------------------------------
// work_tx_pkg
// Shared definitions for the work-packet transmitter slice.
//   - tx_state_t : 8N1 serializer state encoding (IDLE, START, DATA, STOP)
//   - PKT_W      : width of one work packet (midstate + data2)
//   - bit_cyc()  : clock cycles per serial bit, truncated integer division
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package work_tx_pkg;

    localparam int PKT_W = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic int bit_cyc(input int clk_frq, input int baud);
        return clk_frq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// One-byte 8N1 serializer. A byte is latched when start is seen in IDLE, or in
// the last cycle of STOP, so consecutive bytes follow with no idle gap.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   launch request for tx_byte
//   tx_byte  in   byte to send (LSB first)
//   busy     out  serializer is not idle
//   byte_end out  last cycle of the stop bit (combinational)
//   txd      out  registered serial line, idle high
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_core
    import work_tx_pkg::*;
#(
    parameter int BIT_CYC = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       byte_end,
    output logic       txd
);

    localparam int BW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYC - 1);

    tx_state_t     state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    data, data_nxt;
    logic          txd_nxt;
    logic          bit_done;

    // State register; txd is registered from the next-state logic so the line
    // changes on the same edge as the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            data     <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            data     <= data_nxt;
            txd      <= txd_nxt;
        end
    end

    assign bit_done = (baud_cnt == BAUD_LAST);
    assign busy     = (state != IDLE);

    // Next-state logic. The byte is kept in a right-shifting register so the
    // next line value is always data[1] while in DATA.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_idx;
        data_nxt  = data;
        txd_nxt   = txd;
        byte_end  = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                txd_nxt  = 1'b1;
                if (start) begin
                    state_nxt = START;
                    data_nxt  = tx_byte;
                    bit_nxt   = '0;
                    txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    txd_nxt   = data[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        bit_nxt  = bit_idx + 3'd1;
                        data_nxt = data >> 1;
                        txd_nxt  = data[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    byte_end = 1'b1;
                    baud_nxt = '0;
                    if (start) begin
                        state_nxt = START;
                        data_nxt  = tx_byte;
                        bit_nxt   = '0;
                        txd_nxt   = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
                txd_nxt   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/work_transmit.sv
// -----------------------------------------------------------------------------
// work_transmit
// Serializes one 512-bit work packet {midstate, data2} onto an 8N1 line,
// midstate[255:248] first and data2[7:0] last, matching the receiver's
// shift-left assembly.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   midstate  in   first 256 bits of the packet, sampled on accept
//   data2     in   second 256 bits of the packet, sampled on accept
//   send      in   request, accepted when busy is low
//   busy      out  packet in progress (from cycle after accept)
//   done      out  one-cycle pulse when the final stop bit ends
//   TxD       out  serial line, idle high
//
// Build option: WORK_TX_CHECKSUM_EN appends one byte holding the XOR of all
// payload bytes after the payload.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module work_transmit
    import work_tx_pkg::*;
#(
    parameter int CLK_FRQ = 50_000_000,
    parameter int BAUD    = 115200,
    parameter int NBYTES  = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    input  logic         send,
    output logic         busy,
    output logic         done,
    output logic         TxD
);

    localparam int BIT_CYC = bit_cyc(CLK_FRQ, BAUD);

`ifdef WORK_TX_CHECKSUM_EN
    localparam logic [6:0] LAST_IDX = 7'(NBYTES);
`else
    localparam logic [6:0] LAST_IDX = 7'(NBYTES - 1);
`endif
    localparam logic [6:0] PAY_LAST = 7'(NBYTES - 1);

    logic [PKT_W-1:0] shreg;
    logic [6:0]       byte_cnt;
    logic             accept;
    logic             launch;
    logic             is_last;
    logic             core_start;
    logic             core_busy;
    logic             byte_end;
    logic [7:0]       next_byte;
    logic [7:0]       tx_byte;
`ifdef WORK_TX_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    // The shift register only holds bytes not yet handed to the serializer:
    // the first byte goes straight from midstate on accept, and each stop-bit
    // completion pops the next one from the top.
    always_comb begin
        accept  = send && !busy && !core_busy;
        is_last = (byte_cnt == LAST_IDX);
        launch  = byte_end && !is_last;
`ifdef WORK_TX_CHECKSUM_EN
        next_byte = (byte_cnt == PAY_LAST) ? csum : shreg[PKT_W-1 -: 8];
`else
        next_byte = shreg[PKT_W-1 -: 8];
`endif
        tx_byte    = accept ? midstate[255:248] : next_byte;
        core_start = accept || launch;
    end

    // Packet bookkeeping: load on accept, pop one byte per stop completion,
    // and end the packet (busy low, done pulse) after the final stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            byte_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                shreg    <= {midstate[247:0], data2, 8'h00};
                byte_cnt <= '0;
                busy     <= 1'b1;
            end else if (byte_end) begin
                if (is_last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 7'd1;
                    if (byte_cnt != PAY_LAST) begin
                        shreg <= shreg << 8;
                    end
                end
            end
        end
    end

`ifdef WORK_TX_CHECKSUM_EN
    // Running XOR of payload bytes as they are handed to the serializer; the
    // first byte seeds it on accept, which also discards the previous packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (accept) begin
            csum <= midstate[255:248];
        end else if (launch && (byte_cnt != PAY_LAST)) begin
            csum <= csum ^ shreg[PKT_W-1 -: 8];
        end
    end
`endif

    uart_tx_core #(
        .BIT_CYC (BIT_CYC)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (core_start),
        .tx_byte  (tx_byte),
        .busy     (core_busy),
        .byte_end (byte_end),
        .txd      (TxD)
    );

endmodule
